vector_lsu_addr_gen: RTL and testbench
======================================

Name: vector_lsu_addr_gen

Overview:
Per-element address sequencer for vector loads and stores. It sits directly downstream of the vector controller/decode stage and consumes its LSU control signals (ld_inst, st_inst, stride_sel, index_str, index_unordered) together with the scalar operands. On each start it walks elements 0..vl-1 and issues one memory request per element over a valid/ready handshake, then pulses done.

Parameters:
XLEN, 32, address, stride and offset width
MAX_VL, 512, maximum element count
VL_W, $clog2(MAX_VL)+1, width of vl and element counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle launch pulse from issue
ld_inst  in  1  load instruction
st_inst  in  1  store instruction
stride_sel  in  1  1 = unit stride, 0 = constant stride (ignored when index_str=1)
index_str  in  1  indexed addressing
index_unordered  in  1  unordered indexed (informational only)
eew  in  2  element width: 00=8b, 01=16b, 10=32b, 11=reserved
base_addr  in  XLEN  rs1 base address
stride  in  XLEN  rs2 byte stride, two's complement
vl  in  VL_W  element count
offset_elem  in  XLEN  index offset for element elem_idx, valid same cycle
elem_idx  out  VL_W  current element number
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  element byte address
mem_we  out  1  1 = store
mem_size  out  2  eew of the current request
busy  out  1  sequencer active
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0; all internal registers 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - A start is accepted only when exactly one of ld_inst/st_inst is set and eew != 11. Any other start is dropped: no state change, no done.
  - On an accepted start, latch base_addr, stride, vl, eew, mode and we (= st_inst); clear elem_idx.
  - vl==0 -> DONE. Otherwise -> ISSUE.
- Latency: start in cycle N -> mem_req_valid=1 with element 0 in cycle N+1 (or done=1 in N+1 when vl=0).
- ISSUE:
  - mem_req_valid=1, busy=1.
  - mem_addr, mem_we, mem_size and elem_idx are held stable until mem_req_ready=1.
  - On a handshake with elem_idx==vl_q-1 -> DONE. Otherwise increment elem_idx and advance the accumulator.
- Address rules (all arithmetic modulo 2^XLEN; wrap-around is silent):
  - Unit stride: acc starts at base; acc += (1<<eew) per element; mem_addr=acc.
  - Strided: acc starts at base; acc += stride_q per element (negative and zero strides legal); mem_addr=acc.
  - Indexed: mem_addr = base_q + offset_elem, combinational. The provider must hold offset_elem stable while elem_idx is unchanged.
  - index_unordered does not change the order; requests are always issued in ascending element order.
- DONE: done=1 and busy=1 for exactly one cycle, then -> IDLE. mem_req_valid=0.
- busy=0 only in IDLE. start asserted while busy is ignored.
- mem_req_ready while mem_req_valid=0 has no effect.
- Reset mid-transfer aborts immediately; no done is produced.

Optional Feature:
Macro VEC_LSU_MISALIGN_CHK_EN.
- Defined: adds output misalign (1 bit, reset 0). In ISSUE, if mem_addr is not aligned to eew (16b: addr[0]!=0; 32b: addr[1:0]!=0):
  - no request is issued for that element (mem_req_valid=0);
  - misalign=1 for one cycle together with done;
  - FSM goes straight to DONE, and remaining elements are skipped.
- Not defined: no alignment check; every address is issued as computed.

Decomposition:
- Shared defs header (alongside the existing vector processor defines):
  - lsu_state_e {IDLE, ISSUE, DONE};
  - eew encoding enum eew_e;
  - lsu_mode_e {UNIT, STRIDED, INDEXED}.
- Sub-module vector_lsu_addr_calc: combinational next-address / element-address computation from mode, acc, stride, eew, base and offset. The FSM and counter stay in the top.

Test Plan:
- Unit-stride load: base=0x1000, eew=10, vl=4, ready=1 -> addrs 0x1000, 0x1004, 0x1008, 0x100C in cycles N+1..N+4; mem_we=0; done in N+5 only.
- Strided store: base=0x100, stride=0xFFFFFFF8, eew=00, vl=3 -> addrs 0x100, 0xF8, 0xF0; mem_we=1; mem_size=00.
- Indexed: base=0x2000, offsets {0x10, 0x4, 0x0}, eew=01 -> addrs 0x2010, 0x2004, 0x2000; elem_idx 0, 1, 2.
- Backpressure and corner starts:
  - ready low for 3 cycles at element 1 -> valid, addr and elem_idx held;
  - a second start during the stall is ignored;
  - total of vl handshakes.
- vl=0 or eew=11:
  - vl=0 -> no mem_req_valid, done in N+1;
  - eew=11 or ld_inst=st_inst=1 -> start dropped, busy stays 0.
- Reset asserted mid-transfer at element 2 -> outputs 0 in the same cycle, no done. With VEC_LSU_MISALIGN_CHK_EN: base=0x1002, eew=10 -> misalign=1 and done=1 together, no request issued.

Source files
------------

// File: rtl/vector_lsu_addr_gen_pkg.sv
// Shared definitions for the vector LSU address sequencer:
// FSM states, element-width encoding, addressing modes and an alignment helper.
package vector_lsu_addr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        EEW_8   = 2'b00,
        EEW_16  = 2'b01,
        EEW_32  = 2'b10,
        EEW_RSV = 2'b11
    } eew_e;

    typedef enum logic [1:0] {
        UNIT    = 2'd0,
        STRIDED = 2'd1,
        INDEXED = 2'd2
    } lsu_mode_e;

    // True when the two low address bits are not aligned to the element width.
    function automatic logic addr_misaligned(logic [1:0] lo, eew_e w);
        logic r;
        r = 1'b0;
        unique case (w)
            EEW_16:  r = lo[0];
            EEW_32:  r = |lo;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vector_lsu_addr_calc.sv
// Combinational element address and next-accumulator computation.
// Ports: mode/acc/stride/eew/base/offset in; element address and next acc out.
module vector_lsu_addr_calc
    import vector_lsu_addr_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_mode_e       mode_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] stride_i,
    input  eew_e            eew_i,
    input  logic [XLEN-1:0] base_i,
    input  logic [XLEN-1:0] offset_i,
    output logic [XLEN-1:0] elem_addr_o,
    output logic [XLEN-1:0] next_acc_o
);

    logic [XLEN-1:0] unit_inc;

    assign unit_inc = XLEN'(1) << eew_i;

    always_comb begin
        elem_addr_o = acc_i;
        next_acc_o  = acc_i + stride_i;
        unique case (mode_i)
            UNIT:    next_acc_o  = acc_i + unit_inc;
            INDEXED: elem_addr_o = base_i + offset_i;
            default: next_acc_o  = acc_i + stride_i;
        endcase
    end

endmodule

// File: rtl/vector_lsu_addr_gen.sv
// Per-element vector load/store address sequencer (IDLE -> ISSUE -> DONE).
// Ports: start + LSU controls + scalar operands in; one valid/ready memory
// request per element out, plus busy and a one-cycle done pulse.
// Optional: define VEC_LSU_MISALIGN_CHK_EN to add the misalign output, which
// aborts the sequence on the first element not aligned to eew.
module vector_lsu_addr_gen
    import vector_lsu_addr_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MAX_VL = 512,
    parameter int VL_W   = $clog2(MAX_VL) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            ld_inst,
    input  logic            st_inst,
    input  logic            stride_sel,
    input  logic            index_str,
    input  logic            index_unordered,
    input  logic [1:0]      eew,
    input  logic [XLEN-1:0] base_addr,
    input  logic [XLEN-1:0] stride,
    input  logic [VL_W-1:0] vl,
    input  logic [XLEN-1:0] offset_elem,
    output logic [VL_W-1:0] elem_idx,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [1:0]      mem_size,
`ifdef VEC_LSU_MISALIGN_CHK_EN
    output logic            misalign,
`endif
    output logic            busy,
    output logic            done
);

    lsu_state_e      state_q, state_d;
    lsu_mode_e       mode_q, mode_d;
    eew_e            eew_q, eew_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [XLEN-1:0] stride_q, stride_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [VL_W-1:0] vl_q, vl_d;
    logic [VL_W-1:0] idx_q, idx_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] elem_addr;
    logic [XLEN-1:0] next_acc;
    logic            accept;
    logic            bad_align;
    logic            in_issue;
    lsu_mode_e       new_mode;

    // Ordering is always ascending; the unordered hint carries no behaviour.
    logic unused_hint;
    assign unused_hint = index_unordered;

    vector_lsu_addr_calc #(.XLEN(XLEN)) u_calc (
        .mode_i      (mode_q),
        .acc_i       (acc_q),
        .stride_i    (stride_q),
        .eew_i       (eew_q),
        .base_i      (base_q),
        .offset_i    (offset_elem),
        .elem_addr_o (elem_addr),
        .next_acc_o  (next_acc)
    );

    assign accept = (ld_inst ^ st_inst) && (eew != 2'b11);

    always_comb begin
        new_mode = STRIDED;
        if (index_str)
            new_mode = INDEXED;
        else if (stride_sel)
            new_mode = UNIT;
    end

`ifdef VEC_LSU_MISALIGN_CHK_EN
    assign bad_align = addr_misaligned(elem_addr[1:0], eew_q);
    assign misalign  = mis_q;
`else
    assign bad_align = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        eew_d         = eew_q;
        we_d          = we_q;
        base_d        = base_q;
        stride_d      = stride_q;
        acc_d         = acc_q;
        vl_d          = vl_q;
        idx_d         = idx_q;
        mis_d         = 1'b0;
        mem_req_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && accept) begin
                    mode_d   = new_mode;
                    eew_d    = eew_e'(eew);
                    we_d     = st_inst;
                    base_d   = base_addr;
                    stride_d = stride;
                    acc_d    = base_addr;
                    vl_d     = vl;
                    idx_d    = '0;
                    state_d  = (vl == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (bad_align) begin
                    mis_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        if (idx_q == vl_q - VL_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + VL_W'(1);
                            acc_d = next_acc;
                        end
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= UNIT;
            eew_q    <= EEW_8;
            we_q     <= 1'b0;
            base_q   <= '0;
            stride_q <= '0;
            acc_q    <= '0;
            vl_q     <= '0;
            idx_q    <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            eew_q    <= eew_d;
            we_q     <= we_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            acc_q    <= acc_d;
            vl_q     <= vl_d;
            idx_q    <= idx_d;
            mis_q    <= mis_d;
        end
    end

    // Request attributes are only meaningful while issuing; zero elsewhere.
    assign in_issue = (state_q == ISSUE);
    assign elem_idx = idx_q;
    assign mem_addr = in_issue ? elem_addr : '0;
    assign mem_we   = in_issue & we_q;
    assign mem_size = in_issue ? eew_q : 2'b00;

endmodule

// File: tb/tb_vector_lsu_addr_gen.sv
// Directed self-checking bench for vector_lsu_addr_gen.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_vector_lsu_addr_gen;

    localparam int XLEN = 32;
    localparam int VL_W = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            ld_inst, st_inst;
    logic            stride_sel, index_str, index_unordered;
    logic [1:0]      eew;
    logic [XLEN-1:0] base_addr, stride, offset_elem;
    logic [VL_W-1:0] vl;
    logic [VL_W-1:0] elem_idx;
    logic            mem_req_valid, mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic            busy, done;
`ifdef VEC_LSU_MISALIGN_CHK_EN
    logic            misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int done_cnt = 0;
    int hs0;
    int dn0;

    logic            use_idx = 1'b0;
    logic [XLEN-1:0] offs [4];

    always #5 clk = ~clk;

    vector_lsu_addr_gen dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .ld_inst         (ld_inst),
        .st_inst         (st_inst),
        .stride_sel      (stride_sel),
        .index_str       (index_str),
        .index_unordered (index_unordered),
        .eew             (eew),
        .base_addr       (base_addr),
        .stride          (stride),
        .vl              (vl),
        .offset_elem     (offset_elem),
        .elem_idx        (elem_idx),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_size        (mem_size),
`ifdef VEC_LSU_MISALIGN_CHK_EN
        .misalign        (misalign),
`endif
        .busy            (busy),
        .done            (done)
    );

    always_comb begin
        offset_elem = '0;
        if (use_idx)
            offset_elem = offs[elem_idx[1:0]];
    end

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready)
            hs_cnt <= hs_cnt + 1;
        if (done)
            done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic l, input logic s, input logic ss,
                            input logic ix, input logic [1:0] e,
                            input logic [31:0] b, input logic [31:0] st,
                            input logic [VL_W-1:0] v);
        ld_inst    = l;
        st_inst    = s;
        stride_sel = ss;
        index_str  = ix;
        eew        = e;
        base_addr  = b;
        stride     = st;
        vl         = v;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        base_addr  = 32'hDEAD_BEEF;
        stride     = 32'h0;
        vl         = '0;
    endtask

    task automatic chk_req(input string tag, input logic [31:0] a,
                           input int idx, input logic we, input logic [1:0] sz);
        chk({tag, "_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_idx"}, 32'(elem_idx), 32'(idx));
        chk({tag, "_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_size"}, 32'(mem_size), 32'(sz));
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_dvalid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_dbusy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] ua [4];
        logic [31:0] sa [3];
        ua[0] = 32'h1000; ua[1] = 32'h1004; ua[2] = 32'h1008; ua[3] = 32'h100C;
        sa[0] = 32'h100;  sa[1] = 32'hF8;   sa[2] = 32'hF0;
        offs[0] = 32'h10; offs[1] = 32'h4; offs[2] = 32'h0; offs[3] = 32'h0;

        reset = 1'b1; start = 1'b0; ld_inst = 1'b0; st_inst = 1'b0;
        stride_sel = 1'b0; index_str = 1'b0; index_unordered = 1'b0;
        eew = 2'b00; base_addr = '0; stride = '0; vl = '0;
        mem_req_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_idx", 32'(elem_idx), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // unit-stride load, eew=32b
        hs0 = hs_cnt;
        do_start(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h1000, 32'h0, 10'd4);
        for (int i = 0; i < 4; i++) begin
            chk_req("unit", ua[i], i, 1'b0, 2'b10);
            tick();
        end
        chk_done("unit");
        chk("unit_hs", 32'(hs_cnt - hs0), 32'd4);

        // strided store with negative stride
        do_start(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'hFFFF_FFF8, 10'd3);
        for (int i = 0; i < 3; i++) begin
            chk_req("strd", sa[i], i, 1'b1, 2'b00);
            tick();
        end
        chk_done("strd");

        // indexed load
        use_idx = 1'b1;
        do_start(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h2000, 32'h0, 10'd3);
        chk_req("idx0", 32'h2010, 0, 1'b0, 2'b01);
        tick();
        chk_req("idx1", 32'h2004, 1, 1'b0, 2'b01);
        tick();
        chk_req("idx2", 32'h2000, 2, 1'b0, 2'b01);
        tick();
        chk_done("idx");
        use_idx = 1'b0;

        // backpressure at element 1, with an ignored start during the stall
        hs0 = hs_cnt;
        dn0 = done_cnt;
        do_start(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h3000, 32'h0, 10'd3);
        chk_req("bp0", 32'h3000, 0, 1'b0, 2'b10);
        tick();
        mem_req_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_req("bp_stall", 32'h3004, 1, 1'b0, 2'b10);
            if (k == 0) begin
                ld_inst = 1'b0; st_inst = 1'b1; eew = 2'b00;
                base_addr = 32'h9000; vl = 10'd7; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        mem_req_ready = 1'b1;
        #1;
        chk_req("bp1", 32'h3004, 1, 1'b0, 2'b10);
        tick();
        chk_req("bp2", 32'h3008, 2, 1'b0, 2'b10);
        tick();
        chk_done("bp");
        chk("bp_hs", 32'(hs_cnt - hs0), 32'd3);
        chk("bp_dones", 32'(done_cnt - dn0), 32'd1);

        // vl=0 finishes without a request
        hs0 = hs_cnt;
        do_start(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h500, 32'h0, 10'd0);
        chk_done("vl0");
        chk("vl0_hs", 32'(hs_cnt - hs0), 32'd0);

        // dropped starts
        do_start(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'h600, 32'h0, 10'd2);
        chk("eew3_busy", 32'(busy), 32'd0);
        chk("eew3_valid", 32'(mem_req_valid), 32'd0);
        tick();
        chk("eew3_done", 32'(done), 32'd0);
        do_start(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h600, 32'h0, 10'd2);
        chk("ldst_busy", 32'(busy), 32'd0);
        chk("ldst_valid", 32'(mem_req_valid), 32'd0);
        tick();
        chk("ldst_done", 32'(done), 32'd0);
        do_start(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h600, 32'h0, 10'd2);
        chk("none_busy", 32'(busy), 32'd0);

        // reset mid-transfer at element 2
        dn0 = done_cnt;
        do_start(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h4000, 32'h0, 10'd4);
        tick();
        tick();
        chk_req("rmid", 32'h4002, 2, 1'b1, 2'b00);
        reset = 1'b1;
        #1;
        chk("rmid_valid", 32'(mem_req_valid), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_addr", mem_addr, 32'd0);
        chk("rmid_we", 32'(mem_we), 32'd0);
        chk("rmid_idx", 32'(elem_idx), 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("rmid_nodone", 32'(done_cnt - dn0), 32'd0);
        chk("rmid_idle", 32'(busy), 32'd0);

`ifdef VEC_LSU_MISALIGN_CHK_EN
        hs0 = hs_cnt;
        do_start(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h1002, 32'h0, 10'd4);
        chk("mis_valid", 32'(mem_req_valid), 32'd0);
        chk("mis_early", 32'(misalign), 32'd0);
        tick();
        chk("mis_flag", 32'(misalign), 32'd1);
        chk_done("mis");
        chk("mis_clr", 32'(misalign), 32'd0);
        chk("mis_hs", 32'(hs_cnt - hs0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
